// File: rtl/gaussianblur_bus_responder.sv
// Gaussianblur bus-port responder: 128-bit word memory behind a request FSM and a FWFT response FIFO.
// Optional GAUSSIANBLUR_BUS_RSP_WRAP_EN: addresses wrap modulo MEM_DEPTH instead of dropping/zeroing.
module gaussianblur_bus_responder #(
   parameter int MEM_DEPTH = 16,
   parameter int RSP_DEPTH = 4
) (
   input  logic         ap_clk,
   input  logic         ap_rst_n,
   input  logic         req_write,
   input  logic         req_din,
   input  logic [31:0]  address,
   input  logic [31:0]  size,
   input  logic [127:0] dataout,
   output logic         req_full_n,
   input  logic         rsp_read,
   output logic         rsp_empty_n,
   output logic         rsp_dout,
   output logic [127:0] datain
);

   localparam int AW = $clog2(MEM_DEPTH);
   localparam int PW = $clog2(RSP_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(RSP_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_WRITE
   } state_t;

   state_t        state;
   logic [31:0]   addr;
   logic [31:0]   left;
   logic [127:0]  wdata;
   logic [127:0]  mem [MEM_DEPTH];

   logic [128:0]  q [RSP_DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] cnt;

   logic          full;
   logic          empty;
   logic          pop;
   logic          push_ok;
   logic          push;
   logic [128:0]  push_tok;
   logic          in_range;
   logic [127:0]  rd_word;
   logic          mem_we;

   assign full    = (cnt == FULL_CNT);
   assign empty   = (cnt == '0);
   assign pop     = rsp_read && !empty;
   // A full FIFO still takes a token when the head leaves the same cycle.
   assign push_ok = !full || pop;
   assign push    = (state != S_IDLE) && push_ok;

`ifdef GAUSSIANBLUR_BUS_RSP_WRAP_EN
   assign in_range = 1'b1;
`else
   assign in_range = (addr[31:AW] == '0);
`endif

   assign rd_word = in_range ? mem[addr[AW-1:0]] : '0;
   assign mem_we  = (state == S_WRITE) && push_ok && in_range;

   always_comb begin
      push_tok = {1'b0, rd_word};
      if (state == S_WRITE)
         push_tok = {1'b1, 128'h0};
   end

   assign req_full_n  = (state == S_IDLE);
   assign rsp_empty_n = !empty;
   assign rsp_dout    = empty ? 1'b0 : q[rd_ptr][128];
   assign datain      = empty ? 128'h0 : q[rd_ptr][127:0];

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state <= S_IDLE;
         addr  <= '0;
         left  <= '0;
         wdata <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (req_write) begin
                  if (req_din) begin
                     addr  <= address;
                     wdata <= dataout;
                     state <= S_WRITE;
                  end else if (size != '0) begin
                     addr  <= address;
                     left  <= size;
                     state <= S_READ;
                  end
               end
            end
            S_WRITE: begin
               if (push_ok)
                  state <= S_IDLE;
            end
            S_READ: begin
               if (push_ok) begin
                  addr <= addr + 32'd1;
                  left <= left - 32'd1;
                  if (left == 32'd1)
                     state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         for (int i = 0; i < MEM_DEPTH; i++)
            mem[i] <= '0;
      end else if (mem_we) begin
         mem[addr[AW-1:0]] <= wdata;
      end
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         for (int i = 0; i < RSP_DEPTH; i++)
            q[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) begin
            q[wr_ptr] <= push_tok;
            wr_ptr    <= wr_ptr + 1'b1;
         end
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)
            cnt <= cnt + 1'b1;
         else if (pop && !push)
            cnt <= cnt - 1'b1;
      end
   end

endmodule

// File: doc/gaussianblur_bus_responder.md
# gaussianblur_bus_responder

Memory-side responder for one Gaussianblur bus port (V1 or V2). It replaces the free-running random data source with a small addressable 128-bit memory. It accepts single-beat write requests and burst read requests on the request channel, and returns write acknowledgements and read data through a response FIFO that drives `rsp_dout`, `rsp_empty_n` and `datain`. Two instances, one per bus port, sit directly upstream of the Gaussianblur core's bus inputs in the bitstream-generation top.

## Interface
- `MEM_DEPTH`, 16: number of 128-bit words; power of two, ≥2.
- `RSP_DEPTH`, 4: response FIFO entries; power of two, ≥2.
- `ap_clk` in 1: clock; all logic rising-edge.
- `ap_rst_n` in 1: asynchronous active-low reset. Assertion is asynchronous; deassertion is sampled on `ap_clk`.
- `req_write` in 1: request strobe; the request is accepted when `req_write & req_full_n`.
- `req_din` in 1: request type; 1 = write, 0 = read.
- `address` in 32: word address. Only the low log2(MEM_DEPTH) bits index memory; upper bits are handled per Configuration.
- `size` in 32: read burst length in beats; ignored for writes.
- `dataout` in 128: write data.
- `req_full_n` out 1: high when a request can be accepted.
- `rsp_read` in 1: pops the FIFO head when `rsp_empty_n` is high; ignored when the FIFO is empty.
- `rsp_empty_n` out 1: FIFO non-empty.
- `rsp_dout` out 1: head token type; 1 = write ack, 0 = read beat.
- `datain` out 128: head data. Zero for write acks.

## Operation
- Reset: all memory words, FIFO and state clear. Outputs go to `req_full_n`=1, `rsp_empty_n`=0, `rsp_dout`=0, `datain`=0. Reset asserted mid-burst abandons the burst and flushes the FIFO.
- FSM states: IDLE, READ, WRITE.
  - IDLE to WRITE: on accept with `req_din`=1. The request fields are registered.
  - IDLE to READ: on accept with `req_din`=0 and `size`≠0. The address and a 32-bit remaining count are registered.
  - Read with `size`=0: the request is accepted, produces no beats, and the FSM stays in IDLE.
  - WRITE: writes `mem[addr]` and pushes an ack token {`rsp_dout`=1, data 0}. Returns to IDLE once the push succeeds.
  - READ: each cycle a push is allowed, pushes {0, `mem[addr]`}, increments `addr` (modulo 2^32), and decrements the count. Returns to IDLE after the final beat is pushed.
- `req_full_n` is high only in IDLE, so at most one request is outstanding.
- A write completes before any later read is accepted, so read-after-write returns the new data.
- A push is allowed when the FIFO is not full, or when it is full and a pop occurs in the same cycle. A simultaneous push and pop leaves the occupancy unchanged.
- The FIFO is first-word fall-through: head outputs are valid whenever `rsp_empty_n` is high.

## Timing
- Accept edge E0. `req_full_n` drops after E0.
- Write ack: pushed at E1, `rsp_empty_n` visible after E1. `req_full_n` returns high after E1 if the FIFO was not full.
- Read burst of N beats with no backpressure: beat k is pushed at edge E(k+1). `req_full_n` returns high after edge EN.
- A stalled push (FIFO full and no pop) holds the FSM, the address and the count unchanged.
- Pop at edge Ep: the next head is visible after Ep. If the FIFO becomes empty, `rsp_empty_n` falls after Ep.
- Minimum request-to-request spacing is 2 cycles for a write and N+1 cycles for a read.

## Configuration
- `GAUSSIANBLUR_BUS_RSP_WRAP_EN`:
  - Defined: addresses wrap modulo MEM_DEPTH for both writes and read beats; upper address bits are ignored.
  - Undefined: any write with `address` ≥ MEM_DEPTH is dropped, but its ack is still pushed. Any read beat whose current address is ≥ MEM_DEPTH returns 128'h0. Bursts crossing MEM_DEPTH return real data below the boundary and zeros above it.

## Test plan
- Reset, then idle: `req_full_n`=1, `rsp_empty_n`=0, `datain`=0. A read of addr 3, size 1 returns one beat with data 0 and `rsp_dout`=0.
- Write 128'h0123…CDEF to addr 5, pop the ack (`rsp_dout`=1, `datain`=0), then read addr 5, size 1. The read returns 128'h0123…CDEF, first visible 2 cycles after accept.
- Read addr 14, size 4, MEM_DEPTH=16, after writing word value i+1 to address i for every i:
  - With the macro: beats 15, 16, 1, 2.
  - Without the macro: beats 15, 16, 0, 0.
- Backpressure: read size 8 with `rsp_read`=0. Exactly 4 beats are queued and `req_full_n` stays low. Then pop one per cycle: all 8 beats arrive in order with none lost or duplicated.
- Read size 0: accepted, no response, `req_full_n` high again the next cycle.
- Assert `ap_rst_n`=0 mid-burst (after beat 2 of 6). Outputs return to reset values immediately, and no further beats appear after release.
